// File: rtl/spectro_rx_pkg.sv
// Shared state encoding and default geometry for the spectrometer frame receiver.
package spectro_rx_pkg;

  localparam int DEF_RTC_W      = 30;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MAX_WORDS  = 400;

  typedef enum logic [2:0] {
    ST_ARMWAIT = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RTC     = 3'd2,
    ST_DATA    = 3'd3,
    ST_END     = 3'd4
  } rx_state_e;

endpackage

// File: rtl/spectro_frame_rx_if.sv
// Serial link from the transmitter plus the word stream toward the consumer.
interface spectro_frame_rx_if
  import spectro_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              s_frame;
  logic              s_sel;
  logic              s_valid;
  logic              s_data;
  logic [DATA_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output s_frame, s_sel, s_valid, s_data, word_ready,
    input  word_out, word_valid
  );

  modport slave (
    input  s_frame, s_sel, s_valid, s_data, word_ready,
    output word_out, word_valid
  );
endinterface

// File: rtl/rx_word_fifo.sv
// Synchronous word buffer; push into a full buffer succeeds only with a same-cycle pop.
module rx_word_fifo
  import spectro_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty reads as zero so the head word has a defined value out of reset.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spectro_frame_rx.sv
// Spectrometer frame receiver: deserialises timestamp and memory words from a
// bit-serial link and buffers words for a ready/valid consumer.
//
// state   | meaning
// ARMWAIT | after reset or sequence error; wait for s_frame low
// IDLE    | between frames; waiting for a frame start in timestamp section
// RTC     | shifting in RTC_W timestamp bits
// DATA    | assembling DATA_W-bit words, gaps allowed
// END     | pulse frame_done and publish the word count
module spectro_frame_rx
  import spectro_rx_pkg::*;
#(
  parameter int RTC_W      = DEF_RTC_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_WORDS  = DEF_MAX_WORDS
) (
  input  logic             clk,
  input  logic             reset,
  spectro_frame_rx_if.slave bus,
  output logic [RTC_W-1:0] rtc_out,
  output logic             rtc_valid,
  output logic             frame_done,
  output logic [8:0]       frame_words,
  output logic             err_short_rtc,
  output logic             err_partial,
  output logic             err_overflow,
  output logic             err_seq,
  output logic             busy
);
  localparam int CNT_MAX = (RTC_W > DATA_W) ? RTC_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  rx_state_e         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [RTC_W-2:0]  rtc_sh;
  logic [DATA_W-2:0] word_sh;
  logic [8:0]        word_cnt;
  logic              push_q;
  logic [DATA_W-1:0] push_word;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;

  // Full implies non-empty, so word_ready alone means the pop will happen.
  assign overflow       = push_q && fifo_full && !bus.word_ready;
  assign bus.word_valid = !fifo_empty;
  assign bus.word_out   = fifo_dout;
  assign busy           = (state == ST_RTC) || (state == ST_DATA) || (state == ST_END);

  rx_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .din   (push_word),
    .pop   (bus.word_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame sequencing, deserialisation and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_ARMWAIT;
      bit_cnt       <= '0;
      rtc_sh        <= '0;
      word_sh       <= '0;
      word_cnt      <= '0;
      push_q        <= 1'b0;
      push_word     <= '0;
      rtc_out       <= '0;
      rtc_valid     <= 1'b0;
      frame_done    <= 1'b0;
      frame_words   <= '0;
      err_short_rtc <= 1'b0;
      err_partial   <= 1'b0;
      err_overflow  <= 1'b0;
      err_seq       <= 1'b0;
    end else begin
      rtc_valid  <= 1'b0;
      frame_done <= 1'b0;
      push_q     <= 1'b0;
      if (overflow) err_overflow <= 1'b1;
      case (state)
        ST_ARMWAIT: begin
          if (!bus.s_frame) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.s_frame) begin
            if (!bus.s_sel) begin
              state         <= ST_RTC;
              bit_cnt       <= '0;
              word_cnt      <= '0;
              err_short_rtc <= 1'b0;
              err_partial   <= 1'b0;
              err_overflow  <= 1'b0;
              err_seq       <= 1'b0;
            end else begin
              err_seq <= 1'b1;
              state   <= ST_ARMWAIT;
            end
          end
        end
        ST_RTC: begin
          if (!bus.s_frame) begin
            err_short_rtc <= 1'b1;
            state         <= ST_END;
          end else if (bus.s_valid) begin
            rtc_sh <= {rtc_sh[RTC_W-3:0], bus.s_data};
            if (bit_cnt == CNT_W'(RTC_W - 1)) begin
              rtc_out   <= {rtc_sh, bus.s_data};
              rtc_valid <= 1'b1;
              bit_cnt   <= '0;
              state     <= ST_DATA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (!bus.s_frame) begin
            if (bit_cnt != '0) err_partial <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_END;
          end else if (bus.s_valid) begin
            if (bus.s_sel) begin
              word_sh <= {word_sh[DATA_W-3:0], bus.s_data};
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                push_q    <= 1'b1;
                push_word <= {word_sh, bus.s_data};
                bit_cnt   <= '0;
                if (word_cnt < 9'(MAX_WORDS)) word_cnt <= word_cnt + 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              err_seq <= 1'b1;
            end
          end
        end
        ST_END: begin
          frame_done  <= 1'b1;
          frame_words <= word_cnt;
          state       <= ST_IDLE;
        end
        default: state <= ST_ARMWAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_spectro_frame_rx.sv
// Directed bench for spectro_frame_rx: frames, gaps, overflow, short/partial
// frames, sequence errors and mid-frame reset.
module tb_spectro_frame_rx;
  import spectro_rx_pkg::*;

  localparam int RTC_W  = 30;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset;

  logic [RTC_W-1:0] rtc_out;
  logic             rtc_valid;
  logic             frame_done;
  logic [8:0]       frame_words;
  logic             err_short_rtc, err_partial, err_overflow, err_seq;
  logic             busy;

  int n_checks = 0;
  int n_err    = 0;

  int               rtc_pulses = 0;
  logic [RTC_W-1:0] rtc_last   = '0;
  int               fd_count   = 0;
  logic [8:0]       fd_words   = '0;
  logic [DATA_W-1:0] got[$];
  logic [DATA_W-1:0] exp_q[$];

  // 100 MHz clock.
  always #5 clk = ~clk;

  spectro_frame_rx_if #(.DATA_W(DATA_W)) bus ();

  spectro_frame_rx #(
    .RTC_W      (RTC_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (4),
    .MAX_WORDS  (400)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .rtc_out       (rtc_out),
    .rtc_valid     (rtc_valid),
    .frame_done    (frame_done),
    .frame_words   (frame_words),
    .err_short_rtc (err_short_rtc),
    .err_partial   (err_partial),
    .err_overflow  (err_overflow),
    .err_seq       (err_seq),
    .busy          (busy)
  );

  // Observe pulses and accepted words mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rtc_valid) begin
      rtc_pulses++;
      rtc_last = rtc_out;
    end
    if (frame_done) begin
      fd_count++;
      fd_words = frame_words;
    end
    if (bus.word_valid && bus.word_ready) got.push_back(bus.word_out);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic sel, input logic b);
    bus.s_sel   = sel;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic start_frame();
    bus.s_frame = 1'b1;
    bus.s_sel   = 1'b0;
    tick();
  endtask

  task automatic send_rtc(input logic [RTC_W-1:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, v[RTC_W-1-i]);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, w[DATA_W-1-i]);
  endtask

  task automatic end_frame();
    bus.s_frame = 1'b0;
    bus.s_sel   = 1'b0;
    bus.s_valid = 1'b0;
    repeat (5) tick();
  endtask

  task automatic clear_obs();
    rtc_pulses = 0;
    fd_count   = 0;
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_words(input string tag);
    int mism;
    mism = 0;
    for (int k = 0; k < got.size(); k++)
      if (k >= exp_q.size() || got[k] !== exp_q[k]) mism++;
    check({tag, "_count"}, got.size(), exp_q.size());
    check({tag, "_data"}, mism, 0);
  endtask

  function automatic logic [3:0] errs();
    return {err_short_rtc, err_partial, err_overflow, err_seq};
  endfunction

  initial begin
    logic [DATA_W-1:0] w;
    bus.s_frame    = 1'b0;
    bus.s_sel      = 1'b0;
    bus.s_valid    = 1'b0;
    bus.s_data     = 1'b0;
    bus.word_ready = 1'b1;
    reset          = 1'b1;
    #1;
    check("rst_rtc_out", rtc_out, 0);
    check("rst_rtc_valid", rtc_valid, 0);
    check("rst_word_out", bus.word_out, 0);
    check("rst_word_valid", bus.word_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_words", frame_words, 0);
    check("rst_errs", errs(), 4'b0000);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Basic frame: timestamp plus three words, consumer always ready.
    clear_obs();
    start_frame();
    send_rtc(30'h2AAAAAAA, RTC_W);
    check("basic_busy", busy, 1);
    exp_q = '{16'h1234, 16'hABCD, 16'h00FF};
    foreach (exp_q[k]) send_word(exp_q[k], DATA_W);
    end_frame();
    check("basic_rtc_pulses", rtc_pulses, 1);
    check("basic_rtc_out", rtc_last, 32'h2AAAAAAA);
    check_words("basic_words");
    check("basic_fd_count", fd_count, 1);
    check("basic_frame_words", fd_words, 3);
    check("basic_errs", errs(), 4'b0000);
    check("basic_busy_after", busy, 0);

    // Two 200-word banks separated by an idle gap.
    clear_obs();
    start_frame();
    send_rtc(30'h0000_0F0F, RTC_W);
    for (int k = 0; k < 400; k++) begin
      w = 16'(k * 7 + 3);
      exp_q.push_back(w);
      send_word(w, DATA_W);
      if (k == 199) begin
        bus.s_sel = 1'b1;
        repeat (5) tick();
      end
    end
    end_frame();
    check_words("bank_words");
    check("bank_frame_words", fd_words, 400);
    check("bank_errs", errs(), 4'b0000);

    // Word count saturates at 400 although all words are still delivered.
    clear_obs();
    start_frame();
    send_rtc(30'h1, RTC_W);
    for (int k = 0; k < 402; k++) send_word(16'h0, DATA_W);
    end_frame();
    check("sat_frame_words", fd_words, 400);
    check("sat_delivered", got.size(), 402);

    // Stalled consumer: six words into a four-entry buffer.
    clear_obs();
    bus.word_ready = 1'b0;
    start_frame();
    send_rtc(30'h15555555, RTC_W);
    for (int k = 0; k < 6; k++) send_word(16'h1000 + 16'(k), DATA_W);
    end_frame();
    check("ovf_err", err_overflow, 1);
    check("ovf_frame_words", fd_words, 6);
    check("ovf_head", bus.word_out, 16'h1000);
    repeat (3) tick();
    check("ovf_head_stable", bus.word_out, 16'h1000);
    exp_q = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
    bus.word_ready = 1'b1;
    repeat (6) tick();
    check_words("ovf_words");
    check("ovf_drained", bus.word_valid, 0);

    // Full buffer with a pop in the same cycle as the push must not drop.
    clear_obs();
    bus.word_ready = 1'b0;
    start_frame();
    send_rtc(30'h15555555, RTC_W);
    for (int k = 0; k < 4; k++) send_word(16'h2000 + 16'(k), DATA_W);
    send_word(16'h2004, DATA_W - 1);
    send_bit(1'b1, 1'b0);
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    end_frame();
    check("pushpop_no_ovf", err_overflow, 0);
    check("pushpop_frame_words", fd_words, 5);
    bus.word_ready = 1'b1;
    repeat (6) tick();
    exp_q = '{16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2004};
    check_words("pushpop_words");

    // Frame drops after 12 timestamp bits.
    clear_obs();
    start_frame();
    send_rtc(30'h3FFFFFFF, 12);
    end_frame();
    check("short_errs", errs(), 4'b1000);
    check("short_rtc_pulses", rtc_pulses, 0);
    check("short_rtc_kept", rtc_out, 32'h15555555);
    check("short_fd_count", fd_count, 1);
    check("short_frame_words", fd_words, 0);

    // Frame opening in the data section: sequence error, no sync until s_frame low.
    clear_obs();
    bus.s_frame = 1'b1;
    bus.s_sel   = 1'b1;
    tick();
    check("seq_idle_err", err_seq, 1);
    send_word(16'hFFFF, DATA_W);
    bus.s_sel = 1'b0;
    tick();
    send_rtc(30'h2AAAAAAA, RTC_W);
    check("seq_idle_busy", busy, 0);
    check("seq_idle_no_rtc", rtc_pulses, 0);
    end_frame();
    check("seq_idle_no_fd", fd_count, 0);

    // Sequence error inside DATA plus a 7-bit partial word at frame end.
    clear_obs();
    start_frame();
    send_rtc(30'h1, RTC_W);
    send_word(16'hC3C3, DATA_W);
    send_bit(1'b0, 1'b1);
    send_word(16'hFFFF, 7);
    end_frame();
    exp_q = '{16'hC3C3};
    check_words("partial_words");
    check("partial_errs", errs(), 4'b0101);
    check("partial_frame_words", fd_words, 1);

    // Reset in the middle of DATA, released while s_frame is still high.
    clear_obs();
    start_frame();
    send_rtc(30'h155, RTC_W);
    send_word(16'h5A5A, DATA_W);
    send_word(16'hFFFF, 5);
    reset = 1'b1;
    #1;
    check("midrst_word_valid", bus.word_valid, 0);
    check("midrst_rtc_out", rtc_out, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_obs();
    send_word(16'hAAAA, DATA_W);
    send_word(16'h5555, 4);
    check("midrst_busy", busy, 0);
    check("midrst_no_word", bus.word_valid, 0);
    bus.s_frame = 1'b0;
    bus.s_sel   = 1'b0;
    repeat (2) tick();
    check("midrst_no_fd", fd_count, 0);
    check("midrst_no_rtc", rtc_pulses, 0);
    start_frame();
    send_rtc(30'h0123ABCD, RTC_W);
    exp_q = '{16'hBEEF, 16'h0001};
    foreach (exp_q[k]) send_word(exp_q[k], DATA_W);
    end_frame();
    check("midrst_rtc", rtc_last, 32'h0123ABCD);
    check("midrst_rtc_pulses", rtc_pulses, 1);
    check_words("midrst_words");
    check("midrst_frame_words", fd_words, 2);
    check("midrst_errs", errs(), 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
